mult16_seq: RTL and testbench

- Sequencer and result collector for the 16x16 bit-serial carry-save multiplier core.
- Accepts a multiplicand/multiplier pair over a valid/ready handshake, holds the multiplicand stable on the core's parallel pins, and streams multiplier bits LSB-first into the core's serial input.
- Deserialises the core's LSB-first serial product bits into a 32-bit word presented on a valid/ready output.
- Because the core has no reset, this block also drains the core's internal state after reset.

---
 rtl/mult16_pkg.sv | 18 +
 rtl/mult16_deser.sv | 33 +++
 rtl/mult16_seq.sv | 138 +++++++++++++
 tb/tb_mult16_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult16_pkg.sv
// Shared types and widths for the mult16_seq sequencer around the
// 16x16 bit-serial carry-save multiplier core.
package mult16_pkg;

    localparam int OP_W       = 16;
    localparam int PROD_W     = 32;
    localparam int RUN_CYCLES = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mult16_deser.sv
// LSB-first serial-to-parallel register for the 32-bit product stream.
// New bits enter at the MSB, so after 32 shifts bit 0 holds the first bit seen.
module mult16_deser
    import mult16_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [PROD_W-1:0] word
);

    logic [PROD_W-1:0] sr_q;
    logic [PROD_W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (shift_en) begin
            sr_d = {bit_in, sr_q[PROD_W-1:1]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign word = sr_q;

endmodule

// File: rtl/mult16_seq.sv
// Sequencer and result collector for the bit-serial multiplier core: drains the
// reset-less core, streams the multiplier LSB-first and collects the product.
module mult16_seq
    import mult16_pkg::*;
#(
    parameter int INIT_CYCLES  = 32,
    parameter int FLUSH_CYCLES = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    // Both sides: a transfer happens on a rising edge where valid && ready;
    // the producer holds data stable while valid is high and ready is low.
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [OP_W-1:0]   s_a,
    input  logic [OP_W-1:0]   s_b,
    output logic [OP_W-1:0]   mul_a,
    output logic              mul_b_bit,
    input  logic              mul_prod_bit,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PROD_W-1:0] m_product,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] B_BITS     = CNT_W'(OP_W);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [OP_W-1:0]    a_reg_q;
    logic [OP_W-1:0]    a_reg_d;
    logic [OP_W-1:0]    b_sr_q;
    logic [OP_W-1:0]    b_sr_d;
    logic               shift_en;
    logic [PROD_W-1:0]  prod_word;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_reg_d  = a_reg_q;
        b_sr_d   = b_sr_q;
        shift_en = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (s_valid) begin
                    a_reg_d = s_a;
                    b_sr_d  = s_b;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Core output is combinational: product bit k is valid in RUN cycle k.
                shift_en = 1'b1;
                b_sr_d   = b_sr_q >> 1;
                if (cnt_q == RUN_LAST) begin
                    cnt_d   = '0;
                    state_d = (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            a_reg_q <= '0;
            b_sr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_reg_q <= a_reg_d;
            b_sr_q  <= b_sr_d;
        end
    end

    mult16_deser u_deser (
        .clock    (clock),
        .reset_n  (reset_n),
        .shift_en (shift_en),
        .bit_in   (mul_prod_bit),
        .word     (prod_word)
    );

    // Only the lower 16 RUN cycles carry multiplier bits; the upper 16 zero
    // cycles push every remaining carry out, leaving the core empty.
    always_comb begin
        mul_a     = '0;
        mul_b_bit = 1'b0;
        if (state_q == ST_RUN || state_q == ST_FLUSH) begin
            mul_a = a_reg_q;
        end
        if (state_q == ST_RUN && cnt_q < B_BITS) begin
            mul_b_bit = b_sr_q[0];
        end
    end

    assign s_ready   = (state_q == ST_IDLE);
    assign m_valid   = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign m_product = prod_word;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mult16_seq.sv
// Bench for mult16_seq: two instances (no flush / 3 flush cycles), each wired
// to a behavioural model of the bit-serial carry-save multiplier core.
`timescale 1ns/1ps
module tb_mult16_seq;
    import mult16_pkg::*;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        int          stall;
    } vec_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [1:0]        s_valid;
    logic [1:0]        s_ready;
    logic [1:0][15:0]  s_a;
    logic [1:0][15:0]  s_b;
    logic [1:0][15:0]  mul_a;
    logic [1:0]        mul_b_bit;
    logic [1:0]        mul_prod_bit;
    logic [1:0]        m_valid;
    logic [1:0]        m_ready;
    logic [1:0][31:0]  m_product;
    logic [1:0]        busy;
    logic [1:0][2:0]   dbg_state;

    logic [1:0][17:0]  core_acc;
    logic [1:0][18:0]  core_s;
    logic              core_seeded = 1'b0;

    int                checks   = 0;
    int                failures = 0;
    logic [31:0]       exp_q[$];

    always #5 clock = ~clock;

    mult16_seq #(.INIT_CYCLES(32), .FLUSH_CYCLES(0)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_a(s_a[0]), .s_b(s_b[0]),
        .mul_a(mul_a[0]), .mul_b_bit(mul_b_bit[0]), .mul_prod_bit(mul_prod_bit[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_product(m_product[0]),
        .busy(busy[0]), .dbg_state(dbg_state[0])
    );

    mult16_seq #(.INIT_CYCLES(32), .FLUSH_CYCLES(3)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_a(s_a[1]), .s_b(s_b[1]),
        .mul_a(mul_a[1]), .mul_b_bit(mul_b_bit[1]), .mul_prod_bit(mul_prod_bit[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_product(m_product[1]),
        .busy(busy[1]), .dbg_state(dbg_state[1])
    );

    // Core model: pending carries plus the current partial product; emit the
    // LSB combinationally and keep the rest, halved, for the next cycle.
    assign core_s[0] = {1'b0, core_acc[0]} + (mul_b_bit[0] ? {3'b0, mul_a[0]} : 19'd0);
    assign core_s[1] = {1'b0, core_acc[1]} + (mul_b_bit[1] ? {3'b0, mul_a[1]} : 19'd0);
    assign mul_prod_bit[0] = core_s[0][0];
    assign mul_prod_bit[1] = core_s[1][0];

    always @(posedge clock) begin
        if (!core_seeded) begin
            core_acc    <= {18'($urandom), 18'($urandom)};
            core_seeded <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                core_acc[i] <= core_s[i][18:1];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // One complete transaction on instance i; called and returns at a negedge.
    task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b,
                         input int stall, input int exp_lat, output logic [31:0] prod);
        int          n;
        int          lat;
        logic [31:0] bseq;
        logic        mula_ok;
        logic [31:0] exp_p;
        prod    = '0;
        bseq    = '0;
        mula_ok = 1'b1;
        s_a[i] = a;
        s_b[i] = b;
        s_valid[i] = 1'b1;
        m_ready[i] = 1'b0;
        n = 0;
        while (!s_ready[i] && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!s_ready[i]) begin
            check("s_ready_timeout", 32'(s_ready[i]), 32'd1);
            s_valid[i] = 1'b0;
            return;
        end
        exp_q.push_back(32'(a) * 32'(b));
        @(negedge clock);
        s_valid[i] = 1'b0;
        lat = 1;
        while (!m_valid[i] && lat < 200) begin
            if (lat <= 32) begin
                bseq[lat-1] = mul_b_bit[i];
                if (mul_a[i] !== a) mula_ok = 1'b0;
            end
            @(negedge clock);
            lat++;
        end
        exp_p = exp_q.pop_front();
        if (!m_valid[i]) begin
            check("m_valid_timeout", 32'(m_valid[i]), 32'd1);
            return;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("mul_b_seq", bseq, {16'h0, b});
        check("mul_a_hold", 32'(mula_ok), 32'd1);
        prod = m_product[i];
        check("product", prod, exp_p);
        for (int k = 0; k < stall; k++) begin
            @(negedge clock);
            check("stall_valid", 32'(m_valid[i]), 32'd1);
            check("stall_product", m_product[i], exp_p);
        end
        m_ready[i] = 1'b1;
        @(negedge clock);
        m_ready[i] = 1'b0;
        check("m_valid_drop", 32'(m_valid[i]), 32'd0);
        check("idle_reentered", 32'(s_ready[i]), 32'd1);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [31:0] prod;
        int          n;
        logic        saw_valid;
        logic [15:0] ra;
        logic [15:0] rb;

        vecs[0] = '{a: 16'h0003, b: 16'h0005, p: 32'h0000000F, stall: 0};
        vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, p: 32'hFFFE0001, stall: 0};
        vecs[2] = '{a: 16'h0001, b: 16'h0001, p: 32'h00000001, stall: 0};
        vecs[3] = '{a: 16'h1234, b: 16'hABCD, p: 32'h0C374FA4, stall: 10};
        vecs[4] = '{a: 16'h0000, b: 16'hFFFF, p: 32'h00000000, stall: 1};
        vecs[5] = '{a: 16'hFFFF, b: 16'h0001, p: 32'h0000FFFF, stall: 0};
        vecs[6] = '{a: 16'h8000, b: 16'h8000, p: 32'h40000000, stall: 2};
        vecs[7] = '{a: 16'h0001, b: 16'h8000, p: 32'h00008000, stall: 0};

        reset_n = 1'b0;
        s_valid = '0;
        m_ready = '0;
        s_a = '0;
        s_b = '0;
        repeat (3) @(negedge clock);
        check("rst_s_ready", 32'(s_ready[0]), 32'd0);
        check("rst_m_valid", 32'(m_valid[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd1);
        check("rst_product", m_product[0], 32'd0);
        check("rst_mul_a", 32'(mul_a[0]), 32'd0);
        check("rst_state", 32'(dbg_state[0]), 32'(ST_INIT));

        // s_valid held high through INIT: must be ignored until IDLE.
        s_a[0] = vecs[0].a;
        s_b[0] = vecs[0].b;
        s_valid[0] = 1'b1;
        reset_n = 1'b1;
        n = 0;
        while (!s_ready[0] && n < 100) begin
            check("init_mul_b", 32'(mul_b_bit[0]), 32'd0);
            @(negedge clock);
            n++;
        end
        check("init_cycles", 32'(n), 32'd32);

        for (int k = 0; k < 8; k++) begin
            do_op(0, vecs[k].a, vecs[k].b, vecs[k].stall, 33, prod);
            check("table_product", prod, vecs[k].p);
        end

        // Abort a full-scale operation at RUN cycle 20 with reset.
        s_a[0] = 16'hFFFF;
        s_b[0] = 16'hFFFF;
        s_valid[0] = 1'b1;
        n = 0;
        while (!s_ready[0] && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        s_valid[0] = 1'b0;
        repeat (20) @(negedge clock);
        check("abort_busy", 32'(busy[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_m_valid", 32'(m_valid[0]), 32'd0);
        check("abort_product", m_product[0], 32'd0);
        check("abort_mul_b", 32'(mul_b_bit[0]), 32'd0);
        check("abort_s_ready", 32'(s_ready[0]), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        saw_valid = 1'b0;
        while (!s_ready[0] && n < 100) begin
            @(negedge clock);
            if (m_valid[0]) saw_valid = 1'b1;
            n++;
        end
        check("reinit_cycles", 32'(n), 32'd32);
        check("abort_no_valid", 32'(saw_valid), 32'd0);
        do_op(0, 16'h0002, 16'h0007, 0, 33, prod);
        check("after_abort", prod, 32'h0000000E);

        // Flush instance: random operands against plain multiplication.
        n = 0;
        while (!s_ready[1] && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("flush_idle_busy", 32'(busy[1]), 32'd0);
        for (int k = 0; k < 1000; k++) begin
            ra = (k % 97 == 0) ? 16'hFFFF : 16'($urandom);
            rb = (k % 89 == 0) ? 16'hFFFF : 16'($urandom);
            do_op(1, ra, rb, $urandom_range(0, 2), 36, prod);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
